// File: rtl/shift_seq_pkg.sv
// Shared types, default widths and the one-bit shift step for shift_sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {SHR, SHRA, SHL, SHC} shift_op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_e;

  localparam int W_DEF  = 32;
  localparam int CW_DEF = 5;

  // The shift step works on a zero-extended word of the largest supported width,
  // so a single function serves every instance width up to MAX_W.
  localparam int MAX_W     = 64;
  localparam int MAX_W_LOG = 6;

  // One 1-bit shift of a w-bit word held in the low bits of 'word'.
  // Bits above msb_idx must be zero on entry. Bits above msb_idx in the
  // result are don't-care; the caller truncates back to w bits.
  function automatic logic [MAX_W-1:0] shift_step(input logic [MAX_W-1:0]     word,
                                                  input logic [MAX_W_LOG-1:0] msb_idx,
                                                  input shift_op_e            op);
    logic [MAX_W-1:0] r;
    logic             msb;
    msb = word[msb_idx];
    r   = '0;
    unique case (op)
      SHR:  r = word >> 1;                  // upper zero extension supplies the fill
      SHRA: begin
        r          = word >> 1;
        r[msb_idx] = msb;                   // sign bit is replicated
      end
      SHL:  r = word << 1;                  // bit w falls off on truncation
      SHC:  r = (word << 1) | MAX_W'(msb);  // old MSB re-enters at bit 0
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down counter with zero flag; it never wraps below zero.
module shift_down_counter
  import shift_seq_pkg::*;
#(
  parameter int cw = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [cw-1:0] din,
  input  logic          decr,
  output logic [cw-1:0] cnt,
  output logic          n
);

  logic [cw-1:0] cnt_q;
  logic [cw-1:0] cnt_d;

  // Next count: load beats decrement; decrement is inhibited at zero.
  always_comb begin
    // NOTE: assign a default first so every path writes cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = din;
    end else if (decr && (cnt_q != '0)) begin
      cnt_d = cnt_q - cw'(1);
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign n   = (cnt_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle one-bit-per-clock shifter loaded from and read back over a shared bus.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int w  = W_DEF,
  parameter int cw = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [w-1:0] bus,
  input  logic         ld_val,
  input  logic         ld_cnt,
  input  logic [1:0]   op,
  input  logic         start,
  input  logic         out_en,
  output logic         busy,
  output logic         done,
  output logic         n
);

  localparam logic [MAX_W_LOG-1:0] MSB_IDX = MAX_W_LOG'(w - 1);

  seq_state_e    state_q;
  seq_state_e    state_d;
  logic [w-1:0]  operand_q;
  logic [w-1:0]  operand_d;
  shift_op_e     op_q;
  shift_op_e     op_d;

  logic [cw-1:0] cnt;
  logic          cnt_zero;
  logic          cnt_ld;
  logic          cnt_decr;
  logic          start_ok;
  logic          in_idle;

  assign in_idle  = (state_q == IDLE);
  // A start that shares a cycle with a load is dropped; the loads still happen.
  assign start_ok = in_idle && start && !ld_val && !ld_cnt;
  assign cnt_ld   = in_idle && ld_cnt;

  shift_down_counter #(
    .cw (cw)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .ld   (cnt_ld),
    .din  (bus[cw-1:0]),
    .decr (cnt_decr),
    .cnt  (cnt),
    .n    (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a zero count skips straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = cnt_zero ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == cw'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; the counter decrements on every SHIFT cycle.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    cnt_decr = (state_q == SHIFT);
  end

  // Operand and latched-op next values: loads and start only act in IDLE.
  always_comb begin
    operand_d = operand_q;
    op_d      = op_q;
    if (in_idle) begin
      if (ld_val) begin
        operand_d = bus;
      end
      if (start_ok) begin
        op_d = shift_op_e'(op);
      end
    end else if (state_q == SHIFT) begin
      operand_d = w'(shift_step(MAX_W'(operand_q), MSB_IDX, op_q));
    end
  end

  // Operand (result) and op registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q <= '0;
      op_q      <= SHR;
    end else begin
      operand_q <= operand_d;
      op_q      <= op_d;
    end
  end

  assign bus = out_en ? operand_q : 'z;
  assign n   = cnt_zero;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  wire  [31:0] bus;
  logic [31:0] tb_drv;
  logic        tb_drv_en;
  logic        ld_val;
  logic        ld_cnt;
  logic [1:0]  op;
  logic        start;
  logic        out_en;
  logic        busy;
  logic        done;
  logic        n;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign bus = tb_drv_en ? tb_drv : 'z;

  shift_sequencer #(
    .w  (32),
    .cw (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .ld_val (ld_val),
    .ld_cnt (ld_cnt),
    .op     (op),
    .start  (start),
    .out_en (out_en),
    .busy   (busy),
    .done   (done),
    .n      (n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the bus for one cycle with the given load strobes.
  task automatic bus_load(input logic [31:0] v, input logic lv, input logic lc);
    tb_drv    = v;
    tb_drv_en = 1'b1;
    ld_val    = lv;
    ld_cnt    = lc;
    @(negedge clk);
    tb_drv_en = 1'b0;
    ld_val    = 1'b0;
    ld_cnt    = 1'b0;
  endtask

  task automatic read_result(input string tag, input logic [31:0] exp);
    out_en = 1'b1;
    #1;
    check(tag, 64'(bus), 64'(exp));
    out_en = 1'b0;
    #1;
  endtask

  // Load operand and count, start, and check latency, flags and result.
  task automatic run_op(input string tag, input logic [31:0] val, input logic [31:0] cnt_v,
                        input shift_op_e o, input logic [31:0] exp, input int exp_cyc);
    int cyc;
    bus_load(val, 1'b1, 1'b0);
    bus_load(cnt_v, 1'b0, 1'b1);
    start = 1'b1;
    op    = o;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy1"}, 64'(busy), 64'd1);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_n_at_done"}, 64'(n), 64'd1);
    @(negedge clk);
    check({tag, "_done_clear"}, 64'({busy, done}), 64'd0);
    read_result({tag, "_result"}, exp);
  endtask

  initial begin
    int done_seen;
    rst       = 1'b1;
    tb_drv    = '0;
    tb_drv_en = 1'b0;
    ld_val    = 1'b0;
    ld_cnt    = 1'b0;
    op        = 2'b00;
    start     = 1'b0;
    out_en    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_n", 64'(n), 64'd1);
    read_result("rst_operand", 32'h0);

    // Main function, several ops and counts
    run_op("shr4",   32'h0000_00F0, 32'd4,  SHR,  32'h0000_000F, 5);
    run_op("shra3",  32'h8000_0000, 32'd3,  SHRA, 32'hF000_0000, 4);
    run_op("shr3",   32'h8000_0000, 32'd3,  SHR,  32'h1000_0000, 4);
    run_op("shc1",   32'h8000_0001, 32'd1,  SHC,  32'h0000_0003, 2);
    run_op("shl31",  32'h0000_0001, 32'd31, SHL,  32'h8000_0000, 32);
    run_op("shc4",   32'hF000_000A, 32'd4,  SHC,  32'h0000_00AF, 5);

    // Bus is released while out_en is low: the bench's own value reads back
    tb_drv    = 32'h5555_AAAA;
    tb_drv_en = 1'b1;
    #1;
    check("bus_released", 64'(bus), 64'h5555_AAAA);
    tb_drv_en = 1'b0;

    // ld_val with out_en recaptures the block's own value
    ld_val = 1'b1;
    out_en = 1'b1;
    @(negedge clk);
    ld_val = 1'b0;
    out_en = 1'b0;
    read_result("self_load", 32'h0000_00AF);

    // Count 0: done in cycle 1, operand unchanged; restart and reload while busy ignored
    bus_load(32'hA5A5_0001, 1'b1, 1'b0);
    bus_load(32'h0, 1'b0, 1'b1);
    start = 1'b1;
    op    = SHL;
    @(negedge clk);
    check("cnt0_done_c1", 64'({busy, done}), 64'h3);
    tb_drv    = 32'd7;
    tb_drv_en = 1'b1;
    ld_cnt    = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    tb_drv_en = 1'b0;
    ld_cnt    = 1'b0;
    start     = 1'b0;
    check("cnt0_no_restart", 64'({busy, done}), 64'h0);
    check("cnt0_cnt_kept", 64'(n), 64'd1);
    read_result("cnt0_operand", 32'hA5A5_0001);

    // Start together with a load is dropped; the load still happens
    tb_drv    = 32'd2;
    tb_drv_en = 1'b1;
    ld_cnt    = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    tb_drv_en = 1'b0;
    ld_cnt    = 1'b0;
    start     = 1'b0;
    check("start_with_ld_busy", 64'(busy), 64'd0);
    check("start_with_ld_n", 64'(n), 64'd0);

    // Reset in cycle 2 of a count-5 SHL discards everything
    bus_load(32'h0000_0003, 1'b1, 1'b0);
    bus_load(32'd5, 1'b0, 1'b1);
    start = 1'b1;
    op    = SHL;
    @(negedge clk);
    start = 1'b0;
    check("midrst_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_n", 64'(n), 64'd1);
    read_result("midrst_operand", 32'h0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
